// File: rtl/secded_pkg.sv
// rtl/secded_pkg.sv - Shared types and codeword layout constants for the SECDED controller
package secded_pkg;

    localparam int PALABRA_W = 8;
    localparam int DATO_W    = 4;
    localparam int SIND_W    = 3;

    // Hamming positions inside palabra_rx; bit 0 carries overall even parity
    localparam int POS_P1 = 1;
    localparam int POS_P2 = 2;
    localparam int POS_D0 = 3;
    localparam int POS_P4 = 4;
    localparam int POS_D1 = 5;
    localparam int POS_D2 = 6;
    localparam int POS_D3 = 7;

    typedef enum logic [1:0] {
        ESPERA     = 2'd0,
        CALCULO    = 2'd1,
        CORRECCION = 2'd2,
        ENTREGA    = 2'd3
    } estado_t;

endpackage

// File: rtl/sindrome_secded.sv
// rtl/sindrome_secded.sv - Combinational syndrome and global parity of a SECDED codeword
module sindrome_secded
    import secded_pkg::*;
(
    input  logic [PALABRA_W-1:0] palabra_i,
    output logic [SIND_W-1:0]    sindrome_o,
    output logic                 global_o
);

    // Each syndrome bit re-checks the Hamming positions whose index has that bit set
    always_comb begin
        sindrome_o[0] = palabra_i[POS_P1] ^ palabra_i[POS_D0] ^ palabra_i[POS_D1] ^ palabra_i[POS_D3];
        sindrome_o[1] = palabra_i[POS_P2] ^ palabra_i[POS_D0] ^ palabra_i[POS_D2] ^ palabra_i[POS_D3];
        sindrome_o[2] = palabra_i[POS_P4] ^ palabra_i[POS_D1] ^ palabra_i[POS_D2] ^ palabra_i[POS_D3];
        global_o      = ^palabra_i;
    end

endmodule

// File: rtl/controlador_secded.sv
// rtl/controlador_secded.sv - SECDED decode controller; optional error counters under CONTADORES_EN
module controlador_secded
    import secded_pkg::*;
#(
    parameter int CUENTA_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 entrada_valida,
    output logic                 entrada_lista,
    input  logic [PALABRA_W-1:0] palabra_rx,
    output logic                 salida_valida,
    input  logic                 salida_lista,
    output logic [DATO_W-1:0]    dato,
    output logic [SIND_W-1:0]    sindrome,
    output logic                 error_simple,
    output logic                 error_doble
`ifdef CONTADORES_EN
    ,
    output logic [CUENTA_W-1:0]  cuenta_simple,
    output logic [CUENTA_W-1:0]  cuenta_doble,
    input  logic                 borrar_cuentas
`endif
);

    estado_t               estado_q;
    logic                  entrada_lista_q;
    logic                  salida_valida_q;
    logic [PALABRA_W-1:0]  palabra_q;
    logic [SIND_W-1:0]     sind_q;
    logic                  g_q;
    logic [DATO_W-1:0]     dato_q;
    logic [SIND_W-1:0]     sindrome_q;
    logic                  error_simple_q;
    logic                  error_doble_q;

    logic [SIND_W-1:0]     sind_c;
    logic                  g_c;
    logic [PALABRA_W-1:0]  corregida;
    logic [DATO_W-1:0]     dato_d;
    logic                  error_simple_d;
    logic                  error_doble_d;

    sindrome_secded u_sindrome (
        .palabra_i  (palabra_q),
        .sindrome_o (sind_c),
        .global_o   (g_c)
    );

    // Odd overall parity flips the bit the syndrome points at (bit 0 when s=0);
    // even parity with a non-zero syndrome is a double error and stays uncorrected
    always_comb begin
        corregida      = palabra_q;
        error_simple_d = g_q;
        error_doble_d  = !g_q && (sind_q != '0);
        if (g_q) begin
            corregida = palabra_q ^ (PALABRA_W'(1) << sind_q);
        end
        dato_d = {corregida[POS_D3], corregida[POS_D2], corregida[POS_D1], corregida[POS_D0]};
    end

    // Four-phase pipeline: capture, syndrome, correction, hold until consumed
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado_q        <= ESPERA;
            entrada_lista_q <= 1'b1;
            salida_valida_q <= 1'b0;
            palabra_q       <= '0;
            sind_q          <= '0;
            g_q             <= 1'b0;
            dato_q          <= '0;
            sindrome_q      <= '0;
            error_simple_q  <= 1'b0;
            error_doble_q   <= 1'b0;
        end else begin
            case (estado_q)
                ESPERA: begin
                    if (entrada_valida) begin
                        palabra_q       <= palabra_rx;
                        entrada_lista_q <= 1'b0;
                        estado_q        <= CALCULO;
                    end
                end
                CALCULO: begin
                    sind_q   <= sind_c;
                    g_q      <= g_c;
                    estado_q <= CORRECCION;
                end
                CORRECCION: begin
                    dato_q          <= dato_d;
                    sindrome_q      <= sind_q;
                    error_simple_q  <= error_simple_d;
                    error_doble_q   <= error_doble_d;
                    salida_valida_q <= 1'b1;
                    estado_q        <= ENTREGA;
                end
                ENTREGA: begin
                    if (salida_lista) begin
                        salida_valida_q <= 1'b0;
                        entrada_lista_q <= 1'b1;
                        estado_q        <= ESPERA;
                    end
                end
                default: begin
                    estado_q <= ESPERA;
                end
            endcase
        end
    end

    assign entrada_lista = entrada_lista_q;
    assign salida_valida = salida_valida_q;
    assign dato          = dato_q;
    assign sindrome      = sindrome_q;
    assign error_simple  = error_simple_q;
    assign error_doble   = error_doble_q;

`ifdef CONTADORES_EN
    logic                handshake;
    logic [CUENTA_W-1:0] cuenta_simple_q;
    logic [CUENTA_W-1:0] cuenta_doble_q;

    assign handshake = (estado_q == ENTREGA) && salida_lista;

    // Saturating per-class counters; clearing wins over a same-edge increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cuenta_simple_q <= '0;
            cuenta_doble_q  <= '0;
        end else if (borrar_cuentas) begin
            cuenta_simple_q <= '0;
            cuenta_doble_q  <= '0;
        end else if (handshake) begin
            if (error_simple_q && (cuenta_simple_q != '1)) begin
                cuenta_simple_q <= cuenta_simple_q + CUENTA_W'(1);
            end
            if (error_doble_q && (cuenta_doble_q != '1)) begin
                cuenta_doble_q <= cuenta_doble_q + CUENTA_W'(1);
            end
        end
    end

    assign cuenta_simple = cuenta_simple_q;
    assign cuenta_doble  = cuenta_doble_q;
`else
    logic [CUENTA_W-1:0] cuenta_unused;
    assign cuenta_unused = '0;
`endif

endmodule

// File: tb/tb_controlador_secded.sv
// tb/tb_controlador_secded.sv - Randomized model-checked bench for controlador_secded
module tb_controlador_secded;

    typedef struct packed {
        logic [3:0] dato;
        logic [2:0] s;
        logic       es;
        logic       ed;
    } res_t;

    logic       clk;
    logic       rst;
    logic       entrada_valida;
    logic       entrada_lista;
    logic [7:0] palabra_rx;
    logic       salida_valida;
    logic       salida_lista;
    logic [3:0] dato;
    logic [2:0] sindrome;
    logic       error_simple;
    logic       error_doble;
`ifdef CONTADORES_EN
    logic [7:0] cuenta_simple;
    logic [7:0] cuenta_doble;
    logic       borrar_cuentas;
`endif

    int checks   = 0;
    int failures = 0;
    int ciclo    = 0;
    int modo     = 0;

    // Reference model state
    bit   busy   = 0;
    int   t_acc  = 0;
    res_t cola[$];
    int   exp_cs = 0;
    int   exp_cd = 0;

    controlador_secded #(.CUENTA_W(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .entrada_valida (entrada_valida),
        .entrada_lista  (entrada_lista),
        .palabra_rx     (palabra_rx),
        .salida_valida  (salida_valida),
        .salida_lista   (salida_lista),
        .dato           (dato),
        .sindrome       (sindrome),
        .error_simple   (error_simple),
        .error_doble    (error_doble)
`ifdef CONTADORES_EN
        ,
        .cuenta_simple  (cuenta_simple),
        .cuenta_doble   (cuenta_doble),
        .borrar_cuentas (borrar_cuentas)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nombre, input logic [31:0] real_v, input logic [31:0] esperado);
        checks++;
        if (real_v !== esperado) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nombre, real_v, esperado, ciclo);
        end
    endtask

    // Syndrome = XOR of the indices of all set bits in positions 1..7
    function automatic res_t modelo(input logic [7:0] w);
        res_t       r;
        logic [7:0] c;
        int         s;
        int         unos;
        s    = 0;
        unos = 0;
        for (int k = 0; k < 8; k++) begin
            if (w[k]) begin
                unos++;
                if (k > 0) s = s ^ k;
            end
        end
        c = w;
        r = '0;
        r.s = 3'(s);
        if ((unos % 2) == 1) begin
            c[s] = ~c[s];
            r.es = 1'b1;
        end else if (s != 0) begin
            r.ed = 1'b1;
        end
        r.dato = {c[7], c[6], c[5], c[3]};
        return r;
    endfunction

    function automatic logic [7:0] codificar(input logic [3:0] d);
        logic [7:0] w;
        int         s;
        w    = '0;
        w[3] = d[0];
        w[5] = d[1];
        w[6] = d[2];
        w[7] = d[3];
        s = 0;
        for (int k = 1; k < 8; k++) if (w[k]) s = s ^ k;
        w[1] = s[0];
        w[2] = s[1];
        w[4] = s[2];
        w[0] = ^w[7:1];
        return w;
    endfunction

    function automatic logic [7:0] palabra_aleatoria(input int n_err);
        logic [7:0] w;
        int         a;
        int         b;
        w = codificar(4'($urandom));
        a = $urandom_range(0, 7);
        b = (a + $urandom_range(1, 7)) % 8;
        if (n_err >= 1) w[a] = ~w[a];
        if (n_err >= 2) w[b] = ~w[b];
        return w;
    endfunction

    // Consumer side: ready pattern selected by modo (0 stall, 1 ready, 3 ready+clear, else random)
    initial begin
        salida_lista = 1'b0;
`ifdef CONTADORES_EN
        borrar_cuentas = 1'b0;
`endif
        forever begin
            @(posedge clk);
            #1;
            case (modo)
                0:       salida_lista = 1'b0;
                1, 3:    salida_lista = 1'b1;
                default: salida_lista = ($urandom_range(0, 2) != 0);
            endcase
`ifdef CONTADORES_EN
            borrar_cuentas = (modo == 3);
`endif
        end
    end

    // Compare process: checks every cycle, then predicts the next edge
    initial begin
        res_t e;
        bit   exp_sv;
        bit   hs;
        forever begin
            @(negedge clk);
            ciclo++;
            if (rst) begin
                chk("rst_entrada_lista", 32'(entrada_lista), 32'd1);
                chk("rst_salida_valida", 32'(salida_valida), 32'd0);
                chk("rst_dato", 32'(dato), 32'd0);
                chk("rst_sindrome", 32'(sindrome), 32'd0);
                chk("rst_error_simple", 32'(error_simple), 32'd0);
                chk("rst_error_doble", 32'(error_doble), 32'd0);
`ifdef CONTADORES_EN
                chk("rst_cuenta_simple", 32'(cuenta_simple), 32'd0);
                chk("rst_cuenta_doble", 32'(cuenta_doble), 32'd0);
`endif
                busy   = 0;
                exp_cs = 0;
                exp_cd = 0;
                cola.delete();
            end else begin
                exp_sv = busy && ((ciclo - t_acc) >= 3);
                chk("entrada_lista", 32'(entrada_lista), 32'(!busy));
                chk("salida_valida", 32'(salida_valida), 32'(exp_sv));
`ifdef CONTADORES_EN
                chk("cuenta_simple", 32'(cuenta_simple), 32'(exp_cs));
                chk("cuenta_doble", 32'(cuenta_doble), 32'(exp_cd));
`endif
                hs = 0;
                if (exp_sv && cola.size() > 0) begin
                    e = cola[0];
                    chk("dato", 32'(dato), 32'(e.dato));
                    chk("sindrome", 32'(sindrome), 32'(e.s));
                    chk("error_simple", 32'(error_simple), 32'(e.es));
                    chk("error_doble", 32'(error_doble), 32'(e.ed));
                    if (salida_lista) begin
                        hs = 1;
                        void'(cola.pop_front());
                        busy = 0;
                    end
                end else if (!busy && entrada_valida) begin
                    busy  = 1;
                    t_acc = ciclo;
                    cola.push_back(modelo(palabra_rx));
                end
`ifdef CONTADORES_EN
                if (borrar_cuentas) begin
                    exp_cs = 0;
                    exp_cd = 0;
                end else if (hs) begin
                    if (e.es && exp_cs < 255) exp_cs++;
                    if (e.ed && exp_cd < 255) exp_cd++;
                end
`endif
            end
        end
    end

    task automatic enviar(input logic [7:0] w);
        int n;
        n = 0;
        palabra_rx     = w;
        entrada_valida = 1'b1;
        @(negedge clk);
        while (!entrada_lista && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            failures++;
            $display("FAIL enviar_timeout: got entrada_lista=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        entrada_valida = 1'b0;
        palabra_rx     = 8'($urandom);
    endtask

    task automatic esperar_valida();
        int n;
        n = 0;
        @(negedge clk);
        while (!salida_valida && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL valida_timeout: got salida_valida=0 expected 1 within 20 cycles");
        end
    endtask

    task automatic drenar();
        int n;
        n = 0;
        modo = 1;
        @(negedge clk);
        while ((busy || !entrada_lista) && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL drenar_timeout: got busy=%0d expected 0 within 40 cycles", busy);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        res_t r;
        entrada_valida = 1'b0;
        palabra_rx     = 8'h00;
        rst            = 1'b0;
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Pin the model to hand-decoded codewords
        r = modelo(8'hC3);
        chk("modelo_C3", 32'(r), 32'({4'b1100, 3'b000, 1'b0, 1'b0}));
        r = modelo(8'hE3);
        chk("modelo_E3", 32'(r), 32'({4'b1100, 3'b101, 1'b1, 1'b0}));
        r = modelo(8'hC2);
        chk("modelo_C2", 32'(r), 32'({4'b1100, 3'b000, 1'b1, 1'b0}));
        r = modelo(8'hA3);
        chk("modelo_A3", 32'(r), 32'({4'b1010, 3'b011, 1'b0, 1'b1}));
        chk("codificar_C", 32'(codificar(4'b1100)), 32'h0000_00C3);

        // Directed words: clean, single at position 5, single at bit 0, double
        modo = 1;
        enviar(8'hC3);
        enviar(8'hE3);
        enviar(8'hC2);
        enviar(8'hA3);
        drenar();

        // Backpressure: consumer stalls while a second word is offered
        modo = 0;
        enviar(8'hC3);
        esperar_valida();
        @(posedge clk);
        #2;
        palabra_rx     = 8'hE3;
        entrada_valida = 1'b1;
        repeat (5) @(posedge clk);
        #2;
        chk("bp_dato_literal", 32'(dato), 32'h0000_000C);
        chk("bp_entrada_lista", 32'(entrada_lista), 32'd0);
        entrada_valida = 1'b0;
        modo = 1;
        drenar();

        // Randomized traffic with random consumer readiness
        modo = 2;
        for (int i = 0; i < 200; i++) begin
            enviar(palabra_aleatoria($urandom_range(0, 2)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        drenar();

        // Reset while the word sits in CORRECCION
        enviar(8'hE3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_salida_valida", 32'(salida_valida), 32'd0);
        chk("post_rst_entrada_lista", 32'(entrada_lista), 32'd1);
        chk("post_rst_dato", 32'(dato), 32'd0);
        chk("post_rst_flags", 32'({error_simple, error_doble, sindrome}), 32'd0);
        @(posedge clk);
        #1;

`ifdef CONTADORES_EN
        // Saturation of the single-error counter, then clear on a handshake edge
        modo = 1;
        for (int i = 0; i < 300; i++) begin
            enviar(palabra_aleatoria(1));
        end
        drenar();
        chk("cuenta_simple_sat", 32'(cuenta_simple), 32'd255);
        chk("cuenta_doble_zero", 32'(cuenta_doble), 32'd0);
        modo = 0;
        enviar(palabra_aleatoria(1));
        esperar_valida();
        modo = 3;
        @(posedge clk);
        #2;
        @(posedge clk);
        #2;
        modo = 1;
        @(negedge clk);
        chk("cuenta_simple_borrada", 32'(cuenta_simple), 32'd0);
        drenar();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 50000 cycles");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controlador_secded.md
CONTROLADOR_SECDED -- requirements
Module: controlador_secded

Interface
REQ-001 The block SHALL have parameter CUENTA_W, default 8, the width of each error counter.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port entrada_valida, input, 1 bit: palabra_rx is valid.
REQ-005 The block SHALL have port entrada_lista, output, 1 bit: the block can accept a codeword.
REQ-006 The block SHALL have port palabra_rx, input, 8 bits: received SECDED codeword.
REQ-007 The block SHALL have port salida_valida, output, 1 bit: the result outputs are valid.
REQ-008 The block SHALL have port salida_lista, input, 1 bit: the consumer accepts the result.
REQ-009 The block SHALL have port dato, output, 4 bits: decoded data {d3,d2,d1,d0}.
REQ-010 The block SHALL have port sindrome, output, 3 bits: {s4,s2,s1}, the position of a single error.
REQ-011 The block SHALL have port error_simple, output, 1 bit: a single error was corrected.
REQ-012 The block SHALL have port error_doble, output, 1 bit: an uncorrectable double error was detected.
REQ-013 The block SHALL have ports cuenta_simple and cuenta_doble, outputs, CUENTA_W bits each, and borrar_cuentas, input, 1 bit, all present only under CONTADORES_EN.

Function
REQ-014 The codeword layout SHALL be: palabra_rx[k] is Hamming position k for k=1..7; positions 1, 2 and 4 are parity bits p1, p2 and p4; positions 3, 5, 6 and 7 are d0, d1, d2 and d3; palabra_rx[0] is even overall parity over [7:1].
REQ-015 The syndrome SHALL be s1=^pos{1,3,5,7}, s2=^pos{2,3,6,7} and s4=^pos{4,5,6,7}, with global check g=^palabra_rx[7:0].
REQ-016 Classification SHALL be: s=0 and g=0 means no error; g=1 means single error at position s, where s=0 means bit 0; s≠0 and g=0 means double error.
REQ-017 A single error SHALL be corrected by inverting the bit at position s before the data is extracted.
REQ-018 On a double error, dato SHALL carry the uncorrected data bits, error_doble SHALL be 1 and error_simple SHALL be 0.
REQ-019 The FSM SHALL have the states ESPERA, CALCULO, CORRECCION and ENTREGA.
REQ-020 In ESPERA, entrada_lista SHALL be 1; the codeword is captured on an edge where entrada_valida and entrada_lista are both 1, and the FSM moves to CALCULO.
REQ-021 In CALCULO, the syndrome and g SHALL be registered and the FSM SHALL move to CORRECCION.
REQ-022 In CORRECCION, dato and the flags SHALL be registered and the FSM SHALL move to ENTREGA.
REQ-023 In ENTREGA, salida_valida SHALL be 1 and all outputs SHALL be held stable until salida_lista is 1; on that handshake edge the FSM SHALL move to ESPERA.
REQ-024 salida_valida SHALL rise 3 cycles after the accepting edge, giving at most one word per 4 cycles.
REQ-025 entrada_lista SHALL be 0 in every state other than ESPERA; entrada_valida outside ESPERA SHALL be ignored.

Reset
REQ-026 While rst=1, at any time including mid-operation, the FSM SHALL be in ESPERA and any in-flight word SHALL be discarded.
REQ-027 Reset values SHALL be: entrada_lista=1, salida_valida=0, and dato, sindrome, error_simple, error_doble and the counters all 0.

Configuration
REQ-028 With macro CONTADORES_EN defined, cuenta_simple and cuenta_doble SHALL increment by 1 on each output handshake that carries the matching flag, and SHALL saturate at 2^CUENTA_W-1.
REQ-029 With CONTADORES_EN defined, borrar_cuentas=1 SHALL clear both counters synchronously, taking priority over a simultaneous increment.
REQ-030 Without CONTADORES_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package secded_pkg SHALL hold the FSM state enum, the constants PALABRA_W=8, DATO_W=4 and SIND_W=3, and the layout position constants.
REQ-032 The syndrome and g computation SHALL be one combinational sub-module named sindrome_secded, instantiated once.

Verification
REQ-033 Scenario "clean word": palabra_rx=8'hC3 -> dato=4'b1100, sindrome=0, error_simple=0, error_doble=0, with salida_valida rising 3 cycles after acceptance.
REQ-034 Scenario "single error": palabra_rx=8'hE3 (position 5 flipped) -> dato=4'b1100, sindrome=3'b101, error_simple=1; and palabra_rx=8'hC2 -> dato=4'b1100, sindrome=0, error_simple=1.
REQ-035 Scenario "double error": palabra_rx=8'hA3 (positions 5 and 6 flipped) -> sindrome=3'b011, error_doble=1, error_simple=0.
REQ-036 Scenario "backpressure": salida_lista held 0 for 5 cycles -> outputs stable, entrada_lista=0, and a new entrada_valida is ignored; after salida_lista rises, ESPERA is re-entered 1 cycle later.
REQ-037 Scenario "reset mid-operation": rst pulsed while in CORRECCION -> salida_valida=0, entrada_lista=1, and all outputs are 0.
REQ-038 Scenario "counters" (CONTADORES_EN defined): 300 single-error words -> cuenta_simple=255; then borrar_cuentas asserted coincident with a handshake -> cuenta_simple=0.
